// File: rtl/mem_io_ctrl.sv
// Memory/IO access sequencer: turns one datapath request at a time into timed SRAM strobes
// or a memory-mapped switch/hex transfer, and signals completion with a one-cycle ready pulse.
module mem_io_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    input  logic [15:0] S,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe
);

    typedef enum logic [1:0] {StIdle, StSramAcc, StIoAcc, StDone} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_addr;
    logic        r_we;
    logic [15:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [15:0] r_rdata;
    logic        r_ready;
    logic [15:0] r_hex;
    logic [15:0] r_s_meta;
    logic [15:0] r_s_sync;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_dq_oe;
    logic        w_we_d;
    logic        w_sram_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (mem_req) begin
                    w_state_d = (mem_addr == IO_ADDR) ? StIoAcc : StSramAcc;
                end
            end
            StSramAcc: begin
                if (r_cnt == 4'd0) begin
                    w_state_d = StDone;
                end
            end
            StIoAcc: w_state_d = StDone;
            default: w_state_d = StIdle;
        endcase
        // Strobes are registered from the next state so they line up with SRAM_ACC exactly.
        w_we_d   = (r_state == StIdle) ? mem_we : r_we;
        w_sram_d = (w_state_d == StSramAcc);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
            r_hex    <= '0;
            r_s_meta <= '0;
            r_s_sync <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_s_meta <= S;
            r_s_sync <= r_s_meta;
            r_ready  <= (w_state_d == StDone);
            r_ce_n   <= ~w_sram_d;
            r_oe_n   <= ~(w_sram_d & ~w_we_d);
            r_we_n   <= ~(w_sram_d & w_we_d);
            r_dq_oe  <= w_sram_d & w_we_d;
            case (r_state)
                StIdle: begin
                    if (mem_req) begin
                        r_addr  <= mem_addr;
                        r_we    <= mem_we;
                        r_wdata <= mem_wdata;
                        r_cnt   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                StSramAcc: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            r_rdata <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StIoAcc: begin
                    if (r_we) begin
                        r_hex <= r_wdata;
                    end else begin
                        r_rdata <= r_s_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rdata   = r_rdata;
    assign mem_ready   = r_ready;
    assign CE          = r_ce_n;
    assign UB          = r_ce_n;
    assign LB          = r_ce_n;
    assign OE          = r_oe_n;
    assign WE          = r_we_n;
    assign ADDR        = {4'b0000, r_addr};
    assign sram_dq_out = r_wdata;
    assign sram_dq_oe  = r_dq_oe;
    assign HEX0        = seg7(r_hex[3:0]);
    assign HEX1        = seg7(r_hex[7:4]);
    assign HEX2        = seg7(r_hex[11:8]);
    assign HEX3        = seg7(r_hex[15:12]);

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: SRAM device model plus a transaction-level reference model
// (word memory, switch value, hex register, last read data) checked per access.
module tb_mem_io_ctrl;

    localparam int          W   = 2;
    localparam logic [15:0] IOA = 16'hFFFF;
    localparam logic [6:0]  SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        Clk;
    logic        Reset;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] S;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic        CE, UB, LB, OE, WE;
    logic [19:0] ADDR;
    logic [15:0] sram_dq_in;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;

    mem_io_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(IOA)) dut (
        .Clk(Clk), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .S(S), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
        .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Asynchronous SRAM device model.
    bit [15:0] sram [0:65535];
    always @(posedge Clk) begin
        if (!CE && !WE && sram_dq_oe) sram[ADDR[15:0]] <= sram_dq_out;
    end
    assign sram_dq_in = (!CE && !OE) ? sram[ADDR[15:0]] : 16'h0000;

    // Reference model state.
    bit   [15:0] ref_mem [0:255];
    logic [15:0] ref_rdata;
    logic [15:0] ref_hex;
    logic [15:0] ref_sw;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] hex_exp(input logic [15:0] v);
        return {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
    endfunction

    // One complete access with timing, strobe and data checks.
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          input string tag);
        int  k, lat, ce_lo, we_lo, oe_lo, addr_bad;
        bit  io, got;
        io = (addr == IOA);
        k = 0; lat = -1; got = 0; ce_lo = 0; we_lo = 0; oe_lo = 0; addr_bad = 0;
        @(negedge Clk);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        while (!got && k < 40) begin
            @(negedge Clk);
            k++;
            if (!CE) ce_lo++;
            if (!WE) we_lo++;
            if (!OE) oe_lo++;
            if (!CE && (ADDR !== {4'h0, addr})) addr_bad++;
            if (mem_ready) begin
                got = 1;
                lat = k;
            end
        end
        mem_req = 1'b0;
        if (io) begin
            if (we) ref_hex = wd;
            else    ref_rdata = ref_sw;
        end else begin
            if (we) ref_mem[addr[7:0]] = wd;
            else    ref_rdata = ref_mem[addr[7:0]];
        end
        chk({tag, " latency"}, lat, io ? 2 : W + 1);
        chk({tag, " rdata"}, {16'h0, mem_rdata}, {16'h0, ref_rdata});
        chk({tag, " hex"}, {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, hex_exp(ref_hex)});
        if (io) begin
            chk({tag, " io strobes"}, ce_lo + we_lo + oe_lo, 0);
        end else begin
            chk({tag, " ce cycles"}, ce_lo, W);
            chk({tag, " we cycles"}, we_lo, we ? W : 0);
            chk({tag, " oe cycles"}, oe_lo, we ? 0 : W);
            chk({tag, " addr stable"}, addr_bad, 0);
        end
    endtask

    initial begin
        logic [15:0] a [3];
        int          k, last, idx, pulses;

        Reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; S = '0;
        ref_rdata = '0; ref_hex = '0; ref_sw = '0;
        repeat (3) @(negedge Clk);
        chk("reset strobes", {CE, UB, LB, OE, WE, sram_dq_oe}, 6'b111110);
        chk("reset ready/rdata", {mem_ready, mem_rdata}, 17'h0);
        chk("reset addr/dout", {ADDR, sram_dq_out}, 36'h0);
        chk("reset hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, {4{7'b1000000}}});
        Reset = 1'b0;

        // Directed SRAM write then read-back.
        access(1'b1, 16'h0010, 16'h1234, "wr 0010");
        access(1'b0, 16'h0010, 16'h0000, "rd 0010");
        chk("rd 0010 value", {16'h0, mem_rdata}, 32'h1234);

        // Switch reads through the synchronizer.
        S = 16'h0003; ref_sw = S;
        repeat (3) @(negedge Clk);
        access(1'b0, IOA, 16'h0000, "io rd 3");
        chk("io rd 3 value", {16'h0, mem_rdata}, 32'h0003);
        S = 16'h0001; ref_sw = S;
        repeat (3) @(negedge Clk);
        access(1'b0, IOA, 16'h0000, "io rd 1");

        // Hex write.
        access(1'b1, IOA, 16'hBEEF, "io wr beef");
        chk("beef segments", {4'h0, HEX3, HEX2, HEX1, HEX0},
            {4'h0, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});

        // Back-to-back reads with mem_req held high throughout.
        a[0] = 16'h0041; a[1] = 16'h0042; a[2] = 16'h0043;
        for (int i = 0; i < 3; i++) access(1'b1, a[i], 16'(($urandom & 16'hFFFF)), "b2b prep");
        @(negedge Clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = a[0];
        k = 0; last = 0; idx = 0; pulses = 0;
        while (k < 24) begin
            @(negedge Clk);
            k++;
            if (mem_ready) begin
                pulses++;
                if (idx < 3) begin
                    chk("b2b data", {16'h0, mem_rdata}, {16'h0, ref_mem[a[idx][7:0]]});
                    if (idx == 0) chk("b2b first latency", k, W + 1);
                    else          chk("b2b spacing", k - last, W + 2);
                    ref_rdata = ref_mem[a[idx][7:0]];
                end
                last = k;
                idx++;
                if (idx < 3) mem_addr = a[idx];
                else         mem_req = 1'b0;
            end
        end
        chk("b2b pulse count", pulses, 3);

        // Request dropped right after acceptance still completes once.
        @(negedge Clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = a[1];
        @(negedge Clk);
        mem_req = 1'b0;
        pulses = mem_ready ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (mem_ready) begin
                pulses++;
                chk("drop data", {16'h0, mem_rdata}, {16'h0, ref_mem[a[1][7:0]]});
            end
        end
        ref_rdata = ref_mem[a[1][7:0]];
        chk("drop pulse count", pulses, 1);

        // Randomized mix of SRAM/IO reads and writes.
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            logic [15:0] ad;
            op = $urandom_range(0, 5);
            ad = 16'($urandom_range(0, 255));
            case (op)
                0, 1: access(1'b1, ad, 16'($urandom), "rnd sram wr");
                2, 3: access(1'b0, ad, 16'h0000, "rnd sram rd");
                4: begin
                    S = 16'($urandom); ref_sw = S;
                    repeat (3) @(negedge Clk);
                    access(1'b0, IOA, 16'h0000, "rnd io rd");
                end
                default: access(1'b1, IOA, 16'($urandom), "rnd io wr");
            endcase
        end

        // Reset in the middle of an SRAM write.
        @(negedge Clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'hA5A5;
        @(negedge Clk);
        chk("pre-reset we active", {31'h0, WE}, 32'h0);
        Reset = 1'b1;
        #1;
        mem_req = 1'b0;
        ref_rdata = '0; ref_hex = '0;
        chk("mid reset strobes", {CE, UB, LB, OE, WE, sram_dq_oe}, 6'b111110);
        chk("mid reset ready/rdata", {mem_ready, mem_rdata}, 17'h0);
        chk("mid reset hex", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, {4{7'b1000000}}});
        pulses = 0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (mem_ready) pulses++;
        end
        chk("no ready after reset", pulses, 0);
        access(1'b0, 16'h0010, 16'h0000, "post reset rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
